// File: rtl/enemy_update_scheduler.sv
// Purpose : round-robin sequencer for the enemy datapaths and the shared VGA plot port
//           (erase old box, request one update, wait for done, draw new box).
// Latency : registered outputs; one slot = 2*BOX_W*BOX_H + 3 + U cycles (U = UPDATE cycles).
// Backpr. : waits in UPDATE indefinitely for done_update[idx]; enable only gates new slots.
// Ports   : clk/reset (sync, active-high), enable, space_pressed (restart), packed enemy
//           x/y/colour buses, done_update in; update_enemy, vga_x/y/colour, plot, busy,
//           round_done out.
module enemy_update_scheduler #(
  parameter int         NUM_ENEMIES = 3,
  parameter int         BOX_W       = 4,
  parameter int         BOX_H       = 4,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     space_pressed,
  input  logic [8*NUM_ENEMIES-1:0] enemy_x_bus,
  input  logic [7*NUM_ENEMIES-1:0] enemy_y_bus,
  input  logic [3*NUM_ENEMIES-1:0] enemy_colour_bus,
  input  logic [NUM_ENEMIES-1:0]   done_update,
  output logic [NUM_ENEMIES-1:0]   update_enemy,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     round_done
);

  localparam int IW  = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int DXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int DYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_ENEMIES - 1);
  localparam logic [DXW-1:0] DX_LAST  = DXW'(BOX_W - 1);
  localparam logic [DYW-1:0] DY_LAST  = DYW'(BOX_H - 1);
  localparam logic [8:0]     X_LIM    = 9'(SCREEN_W);
  localparam logic [7:0]     Y_LIM    = 8'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH_OLD, S_ERASE, S_UPDATE, S_LATCH_NEW, S_DRAW, S_NEXT
  } state_t;

  state_t         state, nxt_state;
  logic [IW-1:0]  idx, nxt_idx;
  logic [DXW-1:0] dx, nxt_dx;
  logic [DYW-1:0] dy, nxt_dy;
  logic [7:0]     base_x, nxt_base_x;
  logic [6:0]     base_y, nxt_base_y;
  logic           nxt_round;

  logic [7:0]             sel_x;
  logic [6:0]             sel_y;
  logic [2:0]             sel_colour;
  logic [NUM_ENEMIES-1:0] sel_onehot;
  logic                   done_hit;
  logic [8:0]             sum_x;
  logic [7:0]             sum_y;
  logic                   pixel_state;
  logic                   nxt_plot;
  logic [2:0]             nxt_colour;

  // Slice select for the enemy currently being served.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (idx == IW'(i)) begin
        sel_x      = enemy_x_bus[8*i +: 8];
        sel_y      = enemy_y_bus[7*i +: 7];
        sel_colour = enemy_colour_bus[3*i +: 3];
      end
    end
  end

  assign sel_onehot = NUM_ENEMIES'(1) << idx;
  // Done pulses from datapaths other than the one being served are masked off.
  assign done_hit   = |(done_update & sel_onehot);

  always_comb begin
    nxt_state  = state;
    nxt_idx    = idx;
    nxt_dx     = dx;
    nxt_dy     = dy;
    nxt_base_x = base_x;
    nxt_base_y = base_y;
    nxt_round  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) nxt_state = S_LATCH_OLD;
      end
      S_LATCH_OLD, S_LATCH_NEW: begin
        nxt_base_x = sel_x;
        nxt_base_y = sel_y;
        nxt_dx     = '0;
        nxt_dy     = '0;
        nxt_state  = (state == S_LATCH_OLD) ? S_ERASE : S_DRAW;
      end
      S_ERASE, S_DRAW: begin
        if (dx == DX_LAST && dy == DY_LAST) begin
          nxt_state = (state == S_ERASE) ? S_UPDATE : S_NEXT;
        end else if (dx == DX_LAST) begin
          nxt_dx = '0;
          nxt_dy = dy + 1'b1;
        end else begin
          nxt_dx = dx + 1'b1;
        end
      end
      S_UPDATE: begin
        if (done_hit) nxt_state = S_LATCH_NEW;
      end
      S_NEXT: begin
        if (idx == IDX_LAST) begin
          nxt_idx   = '0;
          nxt_round = 1'b1;
        end else begin
          nxt_idx = idx + 1'b1;
        end
        nxt_state = enable ? S_LATCH_OLD : S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs are a registered function of the state being entered, so a pixel
  // is presented during the same cycle the FSM sits on it.
  assign sum_x       = {1'b0, nxt_base_x} + 9'(nxt_dx);
  assign sum_y       = {1'b0, nxt_base_y} + 8'(nxt_dy);
  assign pixel_state = (nxt_state == S_ERASE) || (nxt_state == S_DRAW);
  assign nxt_plot    = pixel_state && (sum_x < X_LIM) && (sum_y < Y_LIM);
  assign nxt_colour  = (nxt_state == S_DRAW) ? sel_colour : BG_COLOUR;

  always_ff @(posedge clk) begin
    if (reset || space_pressed) begin
      state        <= S_IDLE;
      idx          <= '0;
      dx           <= '0;
      dy           <= '0;
      base_x       <= '0;
      base_y       <= '0;
      update_enemy <= '0;
      plot         <= 1'b0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      round_done   <= 1'b0;
    end else begin
      state        <= nxt_state;
      idx          <= nxt_idx;
      dx           <= nxt_dx;
      dy           <= nxt_dy;
      base_x       <= nxt_base_x;
      base_y       <= nxt_base_y;
      update_enemy <= (nxt_state == S_UPDATE) ? sel_onehot : '0;
      plot         <= nxt_plot;
      round_done   <= nxt_round;
      if (pixel_state) begin
        vga_x      <= sum_x[7:0];
        vga_y      <= sum_y[6:0];
        vga_colour <= nxt_colour;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_enemy_update_scheduler.sv
// Bench for enemy_update_scheduler: expected output trace built from the slot rules,
// checked cycle by cycle, plus literal expectations for the directed scenarios.
module tb_enemy_update_scheduler;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset, enable, space_pressed;
  logic [8*N-1:0] enemy_x_bus;
  logic [7*N-1:0] enemy_y_bus;
  logic [3*N-1:0] enemy_colour_bus;
  logic [N-1:0]   done_update;
  logic [N-1:0]   update_enemy;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           plot, busy, round_done;

  always #5 clk = ~clk;

  enemy_update_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .space_pressed(space_pressed),
    .enemy_x_bus(enemy_x_bus), .enemy_y_bus(enemy_y_bus),
    .enemy_colour_bus(enemy_colour_bus), .done_update(done_update),
    .update_enemy(update_enemy), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .busy(busy), .round_done(round_done)
  );

  // Fake datapaths: current/new positions, colours, and update latency per enemy.
  int   cur_x[N], cur_y[N], new_x[N], new_y[N], lat[N];
  logic [2:0] col[N];

  always_comb begin
    enemy_x_bus      = '0;
    enemy_y_bus      = '0;
    enemy_colour_bus = '0;
    for (int i = 0; i < N; i++) begin
      enemy_x_bus[8*i +: 8]      = cur_x[i][7:0];
      enemy_y_bus[7*i +: 7]      = cur_y[i][6:0];
      enemy_colour_bus[3*i +: 3] = col[i];
    end
  end

  typedef struct {
    logic       plot;
    int         x;
    int         y;
    logic [2:0] c;
    logic [N-1:0] upd;
    logic       rd;
    logic       busy;
  } exp_t;

  exp_t        q[$];
  logic [17:0] plog[$];
  logic        pend_rd;
  int          checks, fails, cyc;
  int          upd_run, busy_cnt, plot_cnt, rd_cnt, updhi_cnt;
  logic        stray_en;
  int          stray_bit;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic p, input int x, input int y, input logic [2:0] c,
                      input logic [N-1:0] u, input logic b);
    exp_t e;
    e.plot = p; e.x = x; e.y = y; e.c = c; e.upd = u; e.busy = b;
    e.rd = pend_rd;
    pend_rd = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_idle();
    push(1'b0, 0, 0, 3'b000, '0, 1'b0);
  endtask

  // A 4x4 box, raster order; off-screen pixels still take a cycle but do not plot.
  task automatic push_box(input int bx, input int by, input logic [2:0] c, input int npx);
    int n;
    n = 0;
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++) begin
        if (n < npx) push((bx + xx < 160) && (by + yy < 120), bx + xx, by + yy, c, '0, 1'b1);
        n++;
      end
  endtask

  task automatic push_slot(input int k, input int draw_px);
    logic [N-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    push(1'b0, 0, 0, 3'b000, '0, 1'b1);
    push_box(cur_x[k], cur_y[k], 3'b000, 16);
    for (int i = 0; i < lat[k]; i++) push(1'b0, 0, 0, 3'b000, oh, 1'b1);
    push(1'b0, 0, 0, 3'b000, '0, 1'b1);
    push_box(new_x[k], new_y[k], col[k], draw_px);
    if (draw_px == 16) begin
      push(1'b0, 0, 0, 3'b000, '0, 1'b1);
      pend_rd = (k == N - 1);
    end
  endtask

  // One clock: datapath reaction just after the edge, then the per-cycle compare at negedge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #2;
    done_update = '0;
    if (update_enemy != '0) begin
      upd_run++;
      for (int k = 0; k < N; k++) begin
        if (update_enemy[k] && upd_run == lat[k]) begin
          done_update[k] = 1'b1;
          cur_x[k] = new_x[k];
          cur_y[k] = new_y[k];
        end
      end
      if (stray_en && upd_run == 1) done_update[stray_bit] = 1'b1;
    end else begin
      upd_run = 0;
    end
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (round_done) rd_cnt++;
    if (update_enemy != '0) updhi_cnt++;
    if (plot) begin
      plot_cnt++;
      plog.push_back({vga_x, vga_y, vga_colour});
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      check("plot", int'(plot), int'(e.plot));
      check("busy", int'(busy), int'(e.busy));
      check("update_enemy", int'(update_enemy), int'(e.upd));
      check("round_done", int'(round_done), int'(e.rd));
      if (e.plot) begin
        check("vga_x", int'(vga_x), e.x);
        check("vga_y", int'(vga_y), e.y);
        check("vga_colour", int'(vga_colour), int'(e.c));
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() > 0 && g < 2000) begin
      tick();
      g++;
    end
    check("trace_drained", q.size(), 0);
    q.delete();
  endtask

  function automatic int pix(input int x, input int y, input int c);
    logic [17:0] v;
    v = {x[7:0], y[6:0], c[2:0]};
    return int'(v);
  endfunction

  int s_busy, s_plot, s_rd, s_upd, s_log, abort_i, s0len;

  initial begin
    reset = 1'b1; enable = 1'b0; space_pressed = 1'b0; done_update = '0;
    checks = 0; fails = 0; cyc = 0; upd_run = 0; pend_rd = 1'b0;
    busy_cnt = 0; plot_cnt = 0; rd_cnt = 0; updhi_cnt = 0;
    stray_en = 1'b0; stray_bit = 2;
    cur_x[0] = 110; cur_y[0] = 60;  new_x[0] = 109; new_y[0] = 60;  col[0] = 3'b100; lat[0] = 3;
    cur_x[1] = 158; cur_y[1] = 118; new_x[1] = 158; new_y[1] = 118; col[1] = 3'b010; lat[1] = 1;
    cur_x[2] = 20;  cur_y[2] = 30;  new_x[2] = 21;  new_y[2] = 31;  col[2] = 3'b111; lat[2] = 1;
    repeat (3) tick();

    check("reset_vga_x", int'(vga_x), 0);
    check("reset_vga_y", int'(vga_y), 0);
    check("reset_colour", int'(vga_colour), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_update", int'(update_enemy), 0);

    // Enemy 0 at (110,60), done after 3 request cycles, moves to x=109.
    s_busy = busy_cnt; s_plot = plot_cnt; s_upd = updhi_cnt; s_log = plog.size();
    reset = 1'b0; enable = 1'b1;
    push_slot(0, 16); push_idle();
    tick(); enable = 1'b0;
    drain();
    check("t1_slot_cycles", busy_cnt - s_busy, 38);
    check("t1_plots", plot_cnt - s_plot, 32);
    check("t1_update_cycles", updhi_cnt - s_upd, 3);
    check("t1_first_erase", int'(plog[s_log]), pix(110, 60, 0));
    check("t1_first_draw", int'(plog[s_log + 16]), pix(109, 60, 4));
    check("t1_last_draw", int'(plog[plog.size() - 1]), pix(112, 63, 4));

    // Enemy 1 at the bottom-right corner: only 4 pixels of each box are on screen.
    s_busy = busy_cnt; s_plot = plot_cnt; s_log = plog.size();
    enable = 1'b1;
    push_slot(1, 16); push_idle();
    tick(); enable = 1'b0;
    drain();
    check("t2_slot_cycles", busy_cnt - s_busy, 36);
    check("t2_plots", plot_cnt - s_plot, 8);
    check("t2_first_erase", int'(plog[s_log]), pix(158, 118, 0));
    check("t2_last_erase", int'(plog[s_log + 3]), pix(159, 119, 0));

    // Full round from reset with immediate done pulses.
    reset = 1'b1;
    tick(); tick();
    cur_x[0] = 40;  cur_y[0] = 50;  new_x[0] = 41;  new_y[0] = 50;  lat[0] = 1;
    cur_x[1] = 158; cur_y[1] = 118; new_x[1] = 150; new_y[1] = 100;
    s_busy = busy_cnt; s_rd = rd_cnt; s_upd = updhi_cnt;
    reset = 1'b0; enable = 1'b1;
    push_slot(0, 16); push_slot(1, 16); push_slot(2, 16); push_idle();
    repeat (74) tick();
    enable = 1'b0;
    drain();
    check("t3_round_done_pulses", rd_cnt - s_rd, 1);
    check("t3_update_cycles", updhi_cnt - s_upd, 3);
    check("t3_round_cycles", busy_cnt - s_busy, 108);

    // Restart key during DRAW pixel 7 of enemy 1.
    new_x[0] = 42;
    enable = 1'b1;
    push_slot(0, 16); push_slot(1, 8);
    abort_i = q.size() - 1;
    push_idle();
    repeat (abort_i + 1) tick();
    space_pressed = 1'b1; enable = 1'b0;
    tick();
    space_pressed = 1'b0;
    check("t4_plot", int'(plot), 0);
    check("t4_update", int'(update_enemy), 0);
    check("t4_busy", int'(busy), 0);
    check("t4_vga_x", int'(vga_x), 0);
    drain();

    // Stray done on enemy 2 while serving enemy 0; enable dropped during enemy 1 ERASE.
    stray_en = 1'b1; lat[0] = 4; lat[1] = 2;
    s_upd = updhi_cnt;
    enable = 1'b1;
    push_slot(0, 16);
    s0len = q.size();
    push_slot(1, 16); push_idle();
    repeat (s0len + 5) tick();
    enable = 1'b0; stray_en = 1'b0;
    drain();
    check("t5_update_cycles", updhi_cnt - s_upd, 6);
    check("t6_idle_busy", int'(busy), 0);

    // Resume serves enemy 2 and closes the round.
    s_rd = rd_cnt;
    enable = 1'b1;
    push_slot(2, 16); push_idle();
    tick(); enable = 1'b0;
    drain();
    check("t6_round_done_pulses", rd_cnt - s_rd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
